// File: rtl/lane_deskew.sv
// lane_deskew: per-lane elastic FIFOs that line up PIPE lanes on a common
// COM (K28.5) symbol, then release one aligned symbol set per cycle.
// Skew overrun, FIFO overflow and post-lock COM misalignment all flush
// the lanes and restart the COM search.

// Per-lane FIFO of {K,Data}. Symbols are only readable while the FIFO is
// non-empty. A write to a full FIFO is dropped unless a read happens on
// the same edge. A flush empties the FIFO and discards the write on that edge.
module lane_deskew_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       gclk,
    input  logic       grst_n,
    input  logic       flush,
    input  logic       wr,
    input  logic       rd,
    input  logic [8:0] wdata,
    output logic [8:0] head,
    output logic       empty,
    output logic       full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [8:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             do_wr;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == FULL_CNT);
    assign head  = mem_q[rd_ptr_q];
    // A read on the same edge frees a slot, so a full FIFO can still accept.
    assign do_wr = wr & (~full | rd);

    // Pointer and occupancy update. A flush wins over any read or write.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd)    rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_wr, rd})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and occupancy state. An asynchronous reset empties the FIFO.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Symbol storage. It has no reset because only the occupied entries are
    // ever read.
    always_ff @(posedge gclk) begin
        if (do_wr && !flush) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

module lane_deskew #(
    parameter int LANES    = 4,
    parameter int DEPTH    = 8,
    parameter int MAX_SKEW = 4
) (
    input  logic               PCLK,
    input  logic               Reset_n,
    input  logic [8*LANES-1:0] Lane_Data,
    input  logic [LANES-1:0]   Lane_DataK,
    input  logic [LANES-1:0]   Lane_Valid,
    input  logic               Deskew_En,
    output logic [8*LANES-1:0] Out_Data,
    output logic [LANES-1:0]   Out_DataK,
    output logic               Out_Valid,
    output logic               Aligned,
    output logic               Deskew_Err
);
    typedef struct packed {
        logic       k;
        logic [7:0] d;
    } sym_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_ALIGNED
    } state_t;

    localparam sym_t COM = '{k: 1'b1, d: 8'hBC};
    localparam int SKW_W = $clog2(MAX_SKEW + 2);
    localparam logic [SKW_W-1:0] SKEW_LIM = SKW_W'(MAX_SKEW);

    state_t                  state_q, state_d;
    logic [LANES-1:0]        parked_q, parked_d;
    logic [SKW_W-1:0]        skew_q, skew_d;
    logic [LANES-1:0][7:0]   odata_q, odata_d;
    logic [LANES-1:0]        odatak_q, odatak_d;
    logic                    ovalid_q, ovalid_d;
    logic                    err_q, err_d;

    sym_t [LANES-1:0]        wsym, head;
    logic [LANES-1:0]        empty, full, wr, pop, is_com;
    logic                    flush, overflow, misalign, skew_tmo, set_pop;

    // Lanes write on every strobe once the block has left IDLE.
    assign wr = Lane_Valid & {LANES{state_q != ST_IDLE}};

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign wsym[gi]   = '{k: Lane_DataK[gi], d: Lane_Data[8*gi +: 8]};
        assign is_com[gi] = (head[gi] == COM);
    end

    lane_deskew_fifo #(.DEPTH(DEPTH)) u_fifo [LANES-1:0] (
        .gclk   (PCLK),
        .grst_n (Reset_n),
        .flush  (flush),
        .wr     (wr),
        .rd     (pop),
        .wdata  (wsym),
        .head   (head),
        .empty  (empty),
        .full   (full)
    );

    assign Out_Data   = odata_q;
    assign Out_DataK  = odatak_q;
    assign Out_Valid  = ovalid_q;
    assign Deskew_Err = err_q;
    assign Aligned    = (state_q == ST_ALIGNED);

    // Next-state logic: COM hunt in SEARCH, lock-step pops in ALIGNED.
    // Then error detection, with Deskew_En low overriding everything.
    always_comb begin
        state_d  = state_q;
        parked_d = parked_q;
        skew_d   = skew_q;
        odata_d  = odata_q;
        odatak_d = odatak_q;
        ovalid_d = 1'b0;
        err_d    = 1'b0;
        flush    = 1'b0;
        pop      = '0;
        skew_tmo = 1'b0;
        misalign = 1'b0;
        set_pop  = 1'b0;

        case (state_q)
            ST_IDLE: state_d = ST_SEARCH;
            ST_SEARCH: begin
                // Unparked lanes drop non-COM heads. A COM head parks its lane.
                pop      = ~parked_q & ~empty & ~is_com;
                parked_d = parked_q | (~empty & is_com);
                if (&parked_q) begin
                    state_d = ST_ALIGNED;
                end else if (|parked_q) begin
                    if (skew_q == SKEW_LIM) skew_tmo = 1'b1;
                    else                    skew_d   = skew_q + 1'b1;
                end else begin
                    skew_d = '0;
                end
            end
            ST_ALIGNED: begin
                if (~|empty) begin
                    pop = '1;
                    if ((|is_com) && !(&is_com)) misalign = 1'b1;
                    else                         set_pop  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A dropped write is an overflow unless the same lane pops this edge.
        overflow = |(wr & full & ~pop);

        // The three error sources share one pulse and one recovery path
        // (flush, then SEARCH), so at most one pulse is raised per edge.
        if (!Deskew_En) begin
            flush   = 1'b1;
            state_d = ST_IDLE;
        end else if (overflow || misalign || skew_tmo) begin
            flush   = 1'b1;
            err_d   = 1'b1;
            state_d = ST_SEARCH;
        end else if (set_pop) begin
            ovalid_d = 1'b1;
            for (int i = 0; i < LANES; i++) begin
                odata_d[i]  = head[i].d;
                odatak_d[i] = head[i].k;
            end
        end

        if (flush) begin
            parked_d = '0;
            skew_d   = '0;
        end
    end

    // Control and output registers. Reset is asynchronous and takes effect
    // even mid-stream.
    always_ff @(posedge PCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            parked_q <= '0;
            skew_q   <= '0;
            odata_q  <= '0;
            odatak_q <= '0;
            ovalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            parked_q <= parked_d;
            skew_q   <= skew_d;
            odata_q  <= odata_d;
            odatak_q <= odatak_d;
            ovalid_q <= ovalid_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_lane_deskew.sv
// Directed bench for lane_deskew (LANES=4, DEPTH=8, MAX_SKEW=4).
module tb_lane_deskew;
    logic        PCLK;
    logic        Reset_n;
    logic [31:0] Lane_Data;
    logic [3:0]  Lane_DataK;
    logic [3:0]  Lane_Valid;
    logic        Deskew_En;
    logic [31:0] Out_Data;
    logic [3:0]  Out_DataK;
    logic        Out_Valid;
    logic        Aligned;
    logic        Deskew_Err;

    int vectors = 0;
    int errors  = 0;
    int dly [4];
    int inj_lane = -1;
    int inj_k    = -1;
    int npulse;
    int aseen;

    lane_deskew #(.LANES(4), .DEPTH(8), .MAX_SKEW(4)) dut (
        .PCLK       (PCLK),
        .Reset_n    (Reset_n),
        .Lane_Data  (Lane_Data),
        .Lane_DataK (Lane_DataK),
        .Lane_Valid (Lane_Valid),
        .Deskew_En  (Deskew_En),
        .Out_Data   (Out_Data),
        .Out_DataK  (Out_DataK),
        .Out_Valid  (Out_Valid),
        .Aligned    (Aligned),
        .Deskew_Err (Deskew_Err)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    function automatic logic [31:0] rep(input logic [7:0] b);
        return {4{b}};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_set(input string tag, input logic [7:0] b, input logic k);
        chk({tag, "_valid"}, 32'(Out_Valid), 32'd1);
        chk({tag, "_data"},  Out_Data, rep(b));
        chk({tag, "_datak"}, 32'(Out_DataK), {28'd0, {4{k}}});
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic idle_in();
        Lane_Valid = '0;
        Lane_Data  = '0;
        Lane_DataK = '0;
    endtask

    // Lane i sends COM at stream cycle dly[i], then D-symbols 00..0F.
    task automatic drive(input int c);
        idle_in();
        for (int i = 0; i < 4; i++) begin
            int k;
            k = c - dly[i];
            if (k >= 0 && k <= 16) begin
                Lane_Valid[i] = 1'b1;
                if (k == 0 || (i == inj_lane && k == inj_k)) begin
                    Lane_Data[8*i +: 8] = 8'hBC;
                    Lane_DataK[i]       = 1'b1;
                end else begin
                    Lane_Data[8*i +: 8] = 8'(k - 1);
                end
            end
        end
    endtask

    initial begin
        // ---- reset state
        Reset_n   = 1'b0;
        Deskew_En = 1'b0;
        idle_in();
        repeat (2) tick();
        chk("rst_data",    Out_Data, 32'd0);
        chk("rst_datak",   32'(Out_DataK), 32'd0);
        chk("rst_valid",   32'(Out_Valid), 32'd0);
        chk("rst_aligned", 32'(Aligned), 32'd0);
        chk("rst_err",     32'(Deskew_Err), 32'd0);
        @(negedge PCLK);
        Reset_n = 1'b1;
        tick();
        chk("idle_aligned", 32'(Aligned), 32'd0);

        // ---- skew 0,1,2,3: lock, COM set first, then 00..0F
        dly = '{0, 1, 2, 3};
        Deskew_En = 1'b1;
        tick();
        npulse = 0;
        for (int c = 0; c <= 24; c++) begin
            drive(c);
            tick();
            if (Deskew_Err) npulse++;
            if (c == 4) chk("t31_prelock", 32'(Aligned), 32'd0);
            if (c == 5) begin
                chk("t31_lock", 32'(Aligned), 32'd1);
                chk("t31_nov",  32'(Out_Valid), 32'd0);
            end
            if (c == 6) chk_set("t31_com", 8'hBC, 1'b1);
            if (c >= 7 && c <= 22) chk_set("t31_d", 8'(c - 7), 1'b0);
            if (c == 23) chk("t31_end", 32'(Out_Valid), 32'd0);
        end
        chk("t31_noerr", 32'(npulse), 32'd0);

        // ---- aligned, lane 2 alone gets COM mid-stream
        dly = '{0, 0, 0, 0};
        inj_lane = 2;
        inj_k    = 5;
        npulse = 0;
        for (int c = 0; c <= 18; c++) begin
            drive(c);
            tick();
            if (Deskew_Err) npulse++;
            if (c == 1) chk_set("t33_com", 8'hBC, 1'b1);
            if (c == 2) chk_set("t33_lat", 8'h00, 1'b0);
            if (c == 5) chk_set("t33_d03", 8'h03, 1'b0);
            if (c == 6) begin
                chk("t33_err",     32'(Deskew_Err), 32'd1);
                chk("t33_nov",     32'(Out_Valid), 32'd0);
                chk("t33_aligned", 32'(Aligned), 32'd0);
                chk("t33_hold",    Out_Data, rep(8'h03));
            end
            if (c == 7) chk("t33_pulse", 32'(Deskew_Err), 32'd0);
        end
        chk("t33_npulse", 32'(npulse), 32'd1);
        inj_lane = -1;
        inj_k    = -1;
        for (int c = 0; c <= 21; c++) begin
            drive(c);
            tick();
            if (c == 1) chk("t33_relock0", 32'(Aligned), 32'd0);
            if (c == 2) chk("t33_relock1", 32'(Aligned), 32'd1);
            if (c == 3) chk_set("t33_rcom", 8'hBC, 1'b1);
            if (c == 4) chk_set("t33_r00", 8'h00, 1'b0);
            if (c == 19) chk_set("t33_r0f", 8'h0F, 1'b0);
            if (c == 20) chk("t33_rend", 32'(Out_Valid), 32'd0);
        end

        // ---- aligned, lane 1 silent DEPTH+1 cycles -> overflow
        for (int c = 0; c <= 12; c++) begin
            idle_in();
            if (c <= 10) begin
                Lane_Valid = (c >= 2) ? 4'b1101 : 4'b1111;
                Lane_Data  = rep(8'(8'h20 + c));
            end
            tick();
            if (c == 1) chk_set("t34_s0", 8'h20, 1'b0);
            if (c == 2) chk_set("t34_s1", 8'h21, 1'b0);
            if (c >= 3 && c <= 10) chk("t34_nov", 32'(Out_Valid), 32'd0);
            if (c == 9) begin
                chk("t34_noerr", 32'(Deskew_Err), 32'd0);
                chk("t34_still", 32'(Aligned), 32'd1);
            end
            if (c == 10) begin
                chk("t34_ovf",     32'(Deskew_Err), 32'd1);
                chk("t34_aligned", 32'(Aligned), 32'd0);
            end
            if (c == 11) chk("t34_pulse", 32'(Deskew_Err), 32'd0);
        end

        // ---- lane 3 five cycles late -> one skew error, no lock
        dly = '{0, 0, 0, 5};
        npulse = 0;
        aseen  = 0;
        for (int c = 0; c <= 23; c++) begin
            drive(c);
            tick();
            if (Deskew_Err) npulse++;
            if (Aligned) aseen++;
            if (c == 5) chk("t32_pre", 32'(Deskew_Err), 32'd0);
            if (c == 6) chk("t32_err", 32'(Deskew_Err), 32'd1);
            if (c == 7) chk("t32_pulse", 32'(Deskew_Err), 32'd0);
        end
        chk("t32_npulse", 32'(npulse), 32'd1);
        chk("t32_nolock", 32'(aseen), 32'd0);
        // recovery with lane 3 two cycles late
        dly = '{0, 0, 0, 2};
        npulse = 0;
        for (int c = 0; c <= 22; c++) begin
            drive(c);
            tick();
            if (Deskew_Err) npulse++;
            if (c == 3) chk("t32_r_pre", 32'(Aligned), 32'd0);
            if (c == 4) chk("t32_r_lock", 32'(Aligned), 32'd1);
            if (c == 5) chk_set("t32_rcom", 8'hBC, 1'b1);
            if (c == 6) chk_set("t32_r00", 8'h00, 1'b0);
            if (c == 21) chk_set("t32_r0f", 8'h0F, 1'b0);
            if (c == 22) chk("t32_rend", 32'(Out_Valid), 32'd0);
        end
        chk("t32_r_noerr", 32'(npulse), 32'd0);

        // ---- async reset mid-stream
        dly = '{0, 0, 0, 0};
        for (int c = 0; c <= 3; c++) begin
            drive(c);
            tick();
        end
        chk_set("t35_pre", 8'h01, 1'b0);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("t35_data",    Out_Data, 32'd0);
        chk("t35_datak",   32'(Out_DataK), 32'd0);
        chk("t35_valid",   32'(Out_Valid), 32'd0);
        chk("t35_aligned", 32'(Aligned), 32'd0);
        chk("t35_err",     32'(Deskew_Err), 32'd0);
        idle_in();
        @(negedge PCLK);
        Reset_n = 1'b1;
        #1;
        chk("t35_rel_valid",   32'(Out_Valid), 32'd0);
        chk("t35_rel_aligned", 32'(Aligned), 32'd0);
        tick();
        // ---- relock from IDLE, then Deskew_En low while aligned
        for (int c = 0; c <= 4; c++) begin
            drive(c);
            if (c == 4) Deskew_En = 1'b0;
            tick();
            if (c == 1) chk("t35_lock0", 32'(Aligned), 32'd0);
            if (c == 2) chk("t35_lock1", 32'(Aligned), 32'd1);
            if (c == 3) chk_set("t35_com", 8'hBC, 1'b1);
            if (c == 4) begin
                chk("t35_dis_aligned", 32'(Aligned), 32'd0);
                chk("t35_dis_valid",   32'(Out_Valid), 32'd0);
                chk("t35_dis_err",     32'(Deskew_Err), 32'd0);
                chk("t35_dis_hold",    Out_Data, rep(8'hBC));
            end
        end
        idle_in();
        tick();
        chk("t35_idle_err",     32'(Deskew_Err), 32'd0);
        chk("t35_idle_aligned", 32'(Aligned), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/lane_deskew.md
LANE_DESKEW -- requirements
Module: lane_deskew

Interface
REQ-001 Parameter LANES, default 4, number of PIPE lanes deskewed (1..16).
REQ-002 Parameter DEPTH, default 8, per-lane FIFO depth in symbols (power of 2, >=4).
REQ-003 Parameter MAX_SKEW, default 4, maximum tolerated inter-lane skew in PCLK cycles (< DEPTH-1).
REQ-004 PCLK  input  1  single block clock, rising edge.
REQ-005 Reset_n  input  1  reset, asynchronous, active-low.
REQ-006 Lane_Data  input  8*LANES  decoded symbols, lane i at [8i+7:8i].
REQ-007 Lane_DataK  input  LANES  K-flag per lane.
REQ-008 Lane_Valid  input  LANES  per-lane symbol strobe.
REQ-009 Deskew_En  input  1  enables deskew operation.
REQ-010 Out_Data  output  8*LANES  aligned symbols, same lane packing.
REQ-011 Out_DataK  output  LANES  aligned K-flags.
REQ-012 Out_Valid  output  1  Out_Data/Out_DataK hold one aligned symbol set.
REQ-013 Aligned  output  1  high while state is ALIGNED.
REQ-014 Deskew_Err  output  1  one-cycle pulse on skew, overflow or misalignment error.

Function
REQ-015 Each lane SHALL own a DEPTH-entry FIFO of {DataK,Data}; a symbol is written at every edge where Lane_Valid[i]=1 and state is not IDLE.
REQ-016 COM is defined as DataK=1 with Data=8'hBC (K28.5).
REQ-017 States SHALL be IDLE, SEARCH, ALIGNED; IDLE->SEARCH at the first edge with Deskew_En=1.
REQ-018 In SEARCH, at each edge, an unparked lane with a non-empty FIFO whose head is not COM SHALL pop and discard its head; a lane whose head is COM SHALL be marked parked and SHALL not pop.
REQ-019 A skew counter SHALL clear when no lane is parked and increment each edge while at least one but not all lanes are parked; when it would exceed MAX_SKEW, Deskew_Err SHALL pulse and all FIFOs SHALL flush, state remaining SEARCH.
REQ-020 When all lanes are parked, state SHALL move to ALIGNED at the next edge; the first set popped in ALIGNED SHALL be the COM set.
REQ-021 In ALIGNED, one symbol SHALL be popped from every lane at an edge iff all FIFOs are non-empty; popped symbols SHALL be registered to Out_Data/Out_DataK with Out_Valid=1 for that cycle, else Out_Valid=0 and Out_Data holds its last value.
REQ-022 Latency: with ALIGNED and all FIFOs empty, a symbol set written at edge N SHALL appear on the outputs with Out_Valid=1 after edge N+1.
REQ-023 In ALIGNED, a popped set in which some but not all lanes carry COM SHALL cause a Deskew_Err pulse, flush, Aligned=0 and return to SEARCH; the faulty set SHALL not be output (Out_Valid=0).
REQ-024 A write to a full FIFO SHALL drop the symbol, pulse Deskew_Err, flush all FIFOs and enter SEARCH from SEARCH or ALIGNED.
REQ-025 Flush SHALL clear all pointers, occupancy counts, parked flags and the skew counter in one edge; symbols presented at the flush edge SHALL be discarded.
REQ-026 Deskew_En=0 in any state SHALL flush and enter IDLE at the next edge without a Deskew_Err pulse; this has priority over every error condition.
REQ-027 Error priority when simultaneous: overflow over misalignment over skew timeout; exactly one Deskew_Err pulse per edge.
REQ-028 Simultaneous write and pop on the same FIFO SHALL keep occupancy unchanged, including when full.

Reset
REQ-029 Reset_n=0 SHALL asynchronously force state IDLE, empty FIFOs, cleared parked flags and skew counter, and Out_Data=0, Out_DataK=0, Out_Valid=0, Aligned=0, Deskew_Err=0, including mid-operation.
REQ-030 After Reset_n rises, the block SHALL behave as from IDLE; no output changes before the first active edge.

Verification
REQ-031 LANES=4, lane skews 0,1,2,3 cycles, COM then D-symbols 00..0F each lane -> Aligned=1, first Out_Valid set is BC/K on all lanes, then identical 00..0F on all lanes.
REQ-032 Lane 3 delayed MAX_SKEW+1=5 cycles behind lane 0 -> one Deskew_Err pulse, Aligned stays 0, recovery after skew fixed to 2.
REQ-033 ALIGNED, then lane 2 alone receives COM mid-stream -> Deskew_Err pulse, Aligned=0, that set not output, re-lock on next all-lane COM.
REQ-034 ALIGNED, lane 1 Lane_Valid held 0 for DEPTH+1 cycles while others stream -> Out_Valid=0 throughout, overflow Deskew_Err pulse, state SEARCH.
REQ-035 Reset_n pulsed low while ALIGNED streaming -> all outputs 0 immediately, Aligned=0; Deskew_En=0 while ALIGNED -> IDLE, no Deskew_Err.
